insert_arbiter: RTL and testbench

INSERT_ARBITER -- requirements
Module: insert_arbiter

---
 rtl/insert_arbiter_pkg.sv | 26 ++
 rtl/rr_lane_packer.sv | 43 ++++
 rtl/insert_arbiter.sv | 145 ++++++++++++++
 tb/tb_insert_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insert_arbiter_pkg.sv
// insert_arbiter_pkg: FSM state type and width helpers
// shared by the insert arbiter and its lane packer.
package insert_arbiter_pkg;

  typedef enum logic {
    ARB_RUN,
    ARB_FLUSH
  } arb_state_e;

  localparam int ARB_GCNT_W = 16;

  // credit counter must hold 0..depth inclusive
  function automatic int cred_w(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // grant count must hold 0..lanes inclusive
  function automatic int lim_w(int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/rr_lane_packer.sv
// rr_lane_packer: scans requesters cyclically from i_ptr, grants up to i_limit,
// packs granted indices onto lanes. Ports: i_valid/i_ptr/i_limit -> o_grant/o_sel/o_cnt.
module rr_lane_packer
  import insert_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_LANES = 4,
  localparam int PW        = ptr_w(NUM_REQ),
  localparam int LW        = lim_w(NUM_LANES)
) (
  input  logic [NUM_REQ-1:0]      i_valid,
  input  logic [PW-1:0]           i_ptr,
  input  logic [LW-1:0]           i_limit,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_LANES*PW-1:0] o_sel,
  output logic [LW-1:0]           o_cnt
);

  always_comb begin
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    o_grant = '0;
    o_sel   = '0;
    o_cnt   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one extra bit so ptr+i never wraps before the modulo
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NUM_REQ))
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      w_idx = w_sum[PW-1:0];
      if (i_valid[w_idx] && (o_cnt < i_limit)) begin
        o_grant[w_idx] = 1'b1;
        for (int l = 0; l < NUM_LANES; l++)
          if (o_cnt == LW'(l))
            o_sel[l*PW +: PW] = w_idx;
        o_cnt = o_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/insert_arbiter.sv
// insert_arbiter: credit-gated multi-lane round-robin insert arbiter with flush.
// Ports: req_* in, ins_* out, deq/flush_req in, flush_done/credits/err_credit out;
// grant_cnt exists only with INSERT_ARBITER_STATS_EN defined.
module insert_arbiter
  import insert_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int NUM_LANES   = 4,
  parameter int QUEUE_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_LANES-1:0]            ins_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] ins_data,
  input  logic                            deq,
  input  logic                            flush_req,
  output logic                            flush_done,
  output logic [cred_w(QUEUE_DEPTH)-1:0]  credits,
`ifdef INSERT_ARBITER_STATS_EN
  output logic [NUM_REQ*16-1:0]           grant_cnt,
`endif
  output logic                            err_credit
);

  localparam int CW = cred_w(QUEUE_DEPTH);
  localparam int PW = ptr_w(NUM_REQ);
  localparam int LW = lim_w(NUM_LANES);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  arb_state_e             r_state;
  logic [PW-1:0]          r_ptr;
  logic [CW-1:0]          r_credits;
  logic                   r_flush_done;
  logic                   r_done_seen;
  logic                   r_err;
  logic [LW-1:0]          w_limit;
  logic [LW-1:0]          w_cnt;
  logic [NUM_LANES*PW-1:0] w_sel;
  logic [PW-1:0]          w_last;
  logic                   w_deq_ok;

  always_comb begin
    w_limit = '0;
    if (r_state == ARB_RUN)
      w_limit = (int'(r_credits) >= NUM_LANES) ?
                LW'(NUM_LANES) : LW'(r_credits);
  end

  rr_lane_packer #(
    .NUM_REQ   (NUM_REQ),
    .NUM_LANES (NUM_LANES)
  ) u_pack (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .i_limit (w_limit),
    .o_grant (req_ready),
    .o_sel   (w_sel),
    .o_cnt   (w_cnt)
  );

  always_comb begin
    w_last    = '0;
    ins_valid = '0;
    ins_data  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_cnt == LW'(l + 1))
        w_last = w_sel[l*PW +: PW];
      if (LW'(l) < w_cnt) begin
        ins_valid[l] = 1'b1;
        for (int r = 0; r < NUM_REQ; r++)
          if (w_sel[l*PW +: PW] == PW'(r))
            ins_data[l*DATA_WIDTH +: DATA_WIDTH] =
              req_data[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // a deq against a full credit pool is bogus: dropped and flagged
  assign w_deq_ok = deq && (r_credits != FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_credits <= FULL;
      r_err     <= 1'b0;
    end else begin
      r_credits <= r_credits - CW'(w_cnt) + CW'(w_deq_ok);
      if (w_cnt != '0)
        r_ptr <= (w_last == PW'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
      if (deq && !w_deq_ok)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_RUN;
      r_flush_done <= 1'b0;
      r_done_seen  <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      unique case (r_state)
        ARB_RUN: begin
          r_done_seen <= 1'b0;
          if (flush_req)
            r_state <= ARB_FLUSH;
        end
        ARB_FLUSH: begin
          if (!flush_req)
            r_state <= ARB_RUN;
          else if ((r_credits == FULL) && !r_done_seen) begin
            r_flush_done <= 1'b1;
            r_done_seen  <= 1'b1;
          end
        end
        default: r_state <= ARB_RUN;
      endcase
    end
  end

  assign credits    = r_credits;
  assign flush_done = r_flush_done;
  assign err_credit = r_err;

`ifdef INSERT_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] r_gcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++)
        if (req_ready[r] && (r_gcnt[r*16 +: 16] != 16'hFFFF))
          r_gcnt[r*16 +: 16] <= r_gcnt[r*16 +: 16] + 16'd1;
    end
  end

  assign grant_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_insert_arbiter.sv
// tb_insert_arbiter: scoreboard bench for insert_arbiter,
// directed grant/credit/flush/reset scenarios.
module tb_insert_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NL = 4;
  localparam int QD = 16;

  localparam int K_RDY = 0;
  localparam int K_IV  = 1;
  localparam int K_ID  = 2;
  localparam int K_CR  = 3;
  localparam int K_FD  = 4;
  localparam int K_ERR = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [NL-1:0]  ins_valid;
  logic [NL*DW-1:0] ins_data;
  logic           deq;
  logic           flush_req;
  logic           flush_done;
  logic [4:0]     credits;
  logic           err_credit;
`ifdef INSERT_ARBITER_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  insert_arbiter #(
    .DATA_WIDTH  (DW),
    .NUM_REQ     (NR),
    .NUM_LANES   (NL),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .deq        (deq),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .credits    (credits),
`ifdef INSERT_ARBITER_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string        tag;
    int           kind;
    logic [127:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(int r);
    return 32'hC0DE_0000 + 32'(r);
  endfunction

  function automatic logic [127:0] ld(int a = -1, int b = -1,
                                      int c = -1, int d = -1);
    logic [127:0] v;
    int s[4];
    v = '0;
    s = '{a, b, c, d};
    for (int l = 0; l < 4; l++)
      if (s[l] >= 0)
        v[l*32 +: 32] = dat(s[l]);
    return v;
  endfunction

  function automatic logic [127:0] observe(int k);
    case (k)
      K_RDY:   return 128'(req_ready);
      K_IV:    return 128'(ins_valid);
      K_ID:    return ins_data;
      K_CR:    return 128'(credits);
      K_FD:    return 128'(flush_done);
      K_ERR:   return 128'(err_credit);
      default: return '1;
    endcase
  endfunction

  task automatic push(string tag, int k, logic [127:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic exp_cyc(string t, logic [3:0] rdy, logic [3:0] iv,
                         logic [127:0] id, int cr, logic fd);
    push({t, ".rdy"}, K_RDY, 128'(rdy));
    push({t, ".iv"},  K_IV,  128'(iv));
    push({t, ".id"},  K_ID,  id);
    push({t, ".cr"},  K_CR,  128'(cr));
    push({t, ".fd"},  K_FD,  128'(fd));
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string t);
    @(negedge clk);
    rst       = 1'b1;
    flush_req = 1'b0;
    req_valid = '0;
    deq       = 1'b0;
    #1;
    push({t, ".cr"},  K_CR,  128'(QD));
    push({t, ".fd"},  K_FD,  128'(0));
    push({t, ".err"}, K_ERR, 128'(0));
    push({t, ".rdy"}, K_RDY, 128'(0));
    push({t, ".iv"},  K_IV,  128'(0));
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    deq       = 1'b0;
    flush_req = 1'b0;
    for (int r = 0; r < NR; r++)
      req_data[r*DW +: DW] = dat(r);
    #1 rst = 1'b1;
    #1;
    push("rst.cr",  K_CR,  128'(QD));
    push("rst.fd",  K_FD,  128'(0));
    push("rst.err", K_ERR, 128'(0));
    push("rst.rdy", K_RDY, 128'(0));
    push("rst.iv",  K_IV,  128'(0));
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // four lanes, all requesters, pointer starts at 0
    req_valid = 4'b1111;
    exp_cyc("all4", 4'b1111, 4'b1111, ld(0, 1, 2, 3), 16, 0);
    cyc();
    // pointer back at 0: req1 precedes req3
    req_valid = 4'b1010;
    exp_cyc("ptr0", 4'b1010, 4'b0011, ld(1, 3), 12, 0);
    cyc();
    req_valid = 4'b0010;
    exp_cyc("one1", 4'b0010, 4'b0001, ld(1), 10, 0);
    cyc();
    req_valid = 4'b1111;
    exp_cyc("wrap2", 4'b1111, 4'b1111, ld(2, 3, 0, 1), 9, 0);
    cyc();
    req_valid = 4'b0111;
    exp_cyc("gap3", 4'b0111, 4'b0111, ld(2, 0, 1), 5, 0);
    cyc();
    // pointer 2, two credits left
    req_valid = 4'b1011;
    exp_cyc("lim2", 4'b1001, 4'b0011, ld(3, 0), 2, 0);
    cyc();
    // zero credits with a deq in the same cycle
    req_valid = 4'b0001;
    deq       = 1'b1;
    exp_cyc("cr0deq", 4'b0000, 4'b0000, ld(), 0, 0);
    cyc();
    deq = 1'b0;
    exp_cyc("cr1", 4'b0001, 4'b0001, ld(0), 1, 0);
    cyc();
    req_valid = '0;
    deq       = 1'b1;
    exp_cyc("deqA", 4'b0000, 4'b0000, ld(), 0, 0);
    cyc();
    exp_cyc("deqB", 4'b0000, 4'b0000, ld(), 1, 0);
    cyc();
    // pointer now 1 after granting req0
    deq       = 1'b0;
    req_valid = 4'b1111;
    exp_cyc("ptr1", 4'b0110, 4'b0011, ld(1, 2), 2, 0);
    cyc();
    req_valid = '0;
    exp_cyc("empty", 4'b0000, 4'b0000, ld(), 0, 0);
    cyc();

    // sixteen grants, then flush and drain
    do_reset("rst2");
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_cyc($sformatf("fill%0d", i), 4'b1111, 4'b1111,
              ld(0, 1, 2, 3), 16 - 4 * i, 0);
      cyc();
    end
    flush_req = 1'b1;
    exp_cyc("fl.enter", 4'b0000, 4'b0000, ld(), 0, 0);
    cyc();
    deq = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_cyc($sformatf("fl.deq%0d", j), 4'b0000, 4'b0000, ld(), j, 0);
      cyc();
    end
    deq = 1'b0;
    exp_cyc("fl.full", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    exp_cyc("fl.done", 4'b0000, 4'b0000, ld(), 16, 1);
    cyc();
    exp_cyc("fl.once", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    exp_cyc("fl.hold", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    flush_req = 1'b0;
    exp_cyc("fl.drop", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    exp_cyc("fl.run", 4'b1111, 4'b1111, ld(0, 1, 2, 3), 16, 0);
    cyc();

    // deq against a full pool
    do_reset("rst3");
    deq = 1'b1;
    push("ovf.err0", K_ERR, 128'(0));
    exp_cyc("ovf", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    deq = 1'b0;
    push("ovf.err1", K_ERR, 128'(1));
    exp_cyc("ovf1", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();
    push("ovf.sticky", K_ERR, 128'(1));
    exp_cyc("ovf2", 4'b0000, 4'b0000, ld(), 16, 0);
    cyc();

    // reset in the middle of a flush
    do_reset("rst4");
    req_valid = 4'b1111;
    exp_cyc("mf.a", 4'b1111, 4'b1111, ld(0, 1, 2, 3), 16, 0);
    cyc();
    req_valid = 4'b0011;
    exp_cyc("mf.b", 4'b0011, 4'b0011, ld(0, 1), 12, 0);
    cyc();
    req_valid = '0;
    flush_req = 1'b1;
    exp_cyc("mf.c", 4'b0000, 4'b0000, ld(), 10, 0);
    cyc();
    req_valid = 4'b1111;
    exp_cyc("mf.gate", 4'b0000, 4'b0000, ld(), 10, 0);
    cyc();
    do_reset("mf.rst");
    req_valid = 4'b1111;
    exp_cyc("mf.run", 4'b1111, 4'b1111, ld(0, 1, 2, 3), 16, 0);
    cyc();
    req_valid = '0;
    exp_cyc("mf.nd0", 4'b0000, 4'b0000, ld(), 12, 0);
    cyc();
    exp_cyc("mf.nd1", 4'b0000, 4'b0000, ld(), 12, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
